pad_loopback_sequencer: RTL and testbench
=========================================

Name: pad_loopback_sequencer

Overview:
Core-side controller for the 12-in/12-out padframe datapath. It drives test patterns onto the output-pad bus, waits for the pads to settle, samples the input-pad bus through a synchronizer, and compares the two. Used for production and bring-up checks of the padframe with an external uo-to-ui loopback. It sits between the core and the sg13g2 IOPadIn/IOPadOut30mA instances, in place of the direct ui-to-uo connection.

Parameters:
WIDTH, 12, number of pad bits on each bus
SETTLE_CYCLES, 4, wait cycles after each drive before the sample window
SYNC_STAGES, 2, flip-flop depth of the ui input synchronizer (minimum 2)

Ports:
clk  input  1  single system clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
mode  input  2  0 walking-one, 1 walking-zero, 2 binary counter, 3 alternating 0x555/0xAAA; latched on start
uo_CORE2PAD  output  WIDTH  registered pattern to the output pads
ui_PAD2CORE  input  WIDTH  raw input-pad values, asynchronous
busy  output  1  high from start acceptance until DONE
done  output  1  one-cycle pulse at end of run
pass  output  1  1 if err_count==0 at end of run; held until next start
err_count  output  8  count of mismatching patterns, saturating at 255
first_fail_pattern  output  WIDTH  driven value at the first mismatch
first_fail_vec  output  WIDTH  sampled value at the first mismatch

Behaviour:
- Reset: state IDLE. uo_CORE2PAD=0, busy=0, done=0, pass=0, err_count=0, first_fail_*=0, synchronizer cleared. A reset asserted mid-run aborts the run at the next edge with no done pulse.
- ui_PAD2CORE passes through a SYNC_STAGES-deep per-bit synchronizer before comparison.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: uo=0. On start=1, latch mode, clear err_count/first_fail_*/pass, reset the pattern index to 0, set busy=1, and go to DRIVE.
- DRIVE: 1 cycle. Register pattern(index) onto uo, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES+SYNC_STAGES cycles, then go to SAMPLE.
- SAMPLE: 1 cycle. Compare the synchronized ui with uo. On mismatch, err_count increments (saturating at 255). If this is the first mismatch, capture first_fail_pattern=uo and first_fail_vec=sync ui. If index is the last, go to DONE; otherwise increment index and go to DRIVE.
- Cost per pattern: P = 2+SETTLE_CYCLES+SYNC_STAGES cycles (8 at defaults).
- Pattern counts N: walking-one and walking-zero WIDTH, counter 2^WIDTH, alternating 2.
  - walking-one: pattern(i)=1<<i
  - walking-zero: pattern(i)=~(1<<i)
  - counter: pattern(i)=i
  - alternating: 0x555, then 0xAAA (WIDTH-masked)
- DONE: 1 cycle. done=1, busy=0, pass=(err_count==0), uo returns to 0, then go to IDLE.
- done is asserted N*P cycles after the start-accept edge.
- start while busy is ignored. start in the DONE cycle is ignored. start held high in IDLE retriggers a new run.
- The index counter is WIDTH+1 bits wide so the counter mode terminates without wrap-around.
- mode changes during a run have no effect.

Optional Feature:
PAD_LOOPBACK_INJECT_EN
- Defined: adds ports inject (input, 1) and inject_idx (input, 4). While inject=1 in a SAMPLE cycle, bit inject_idx of the synchronized ui is inverted before comparison and capture. inject_idx >= WIDTH has no effect. This allows a self-test of the checker without a bad pad.
- Undefined: the ports are absent and the comparison uses the synchronized ui unaltered.

Decomposition:
- Package pad_loopback_pkg:
  - mode enum (MODE_WALK1, MODE_WALK0, MODE_COUNT, MODE_ALT)
  - state enum
  - ERR_MAX=255
  - function pattern_count(mode, width)
  - function pattern_gen(mode, index, width)
- One sub-module, pad_sync: a parameterized N-stage, WIDTH-bit synchronizer with synchronous reset, instantiated once.

Test Plan:
- Walking-one, ideal loopback model with 3-cycle pad delay -> done 96 cycles after start accepted, pass=1, err_count=0, uo=0 afterwards.
- Walking-one, ui bit 5 stuck-at-0 -> err_count=1, first_fail_pattern=0x020, first_fail_vec=0x000, pass=0.
- Alternating mode, ui bits 2/3 swapped -> err_count=2, first_fail_pattern=0x555, first_fail_vec=0x559, done at 16 cycles.
- Counter mode, ui bit 11 stuck-at-1 -> err_count saturates at 255, first_fail_pattern=0x000, first_fail_vec=0x800, done at 4096*8 cycles.
- rst pulsed at cycle 40 of a walking-zero run -> next cycle busy=0, uo=0, err_count=0, no done. start pulsed while busy -> ignored, run length unchanged.
- With PAD_LOOPBACK_INJECT_EN, ideal loopback, inject=1, inject_idx=0 held -> walking-one err_count=12, first_fail_pattern=0x001, first_fail_vec=0x000. With inject_idx=13 -> pass=1.

Source files
------------

// File: rtl/pad_loopback_pkg.sv
// Shared types and pattern helpers for the padframe loopback sequencer.
package pad_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_WALK1 = 2'd0,
    MODE_WALK0 = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic int pattern_count(mode_e m, int width);
    case (m)
      MODE_WALK1, MODE_WALK0: pattern_count = width;
      MODE_COUNT:             pattern_count = 1 << width;
      default:                pattern_count = 2;
    endcase
  endfunction

  // Result is 32 bits wide; callers size-cast down to their bus width.
  function automatic logic [31:0] pattern_gen(mode_e m, logic [31:0] idx, int width);
    logic [31:0] mask;
    logic [31:0] one;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    one  = 32'd1 << idx;
    case (m)
      MODE_WALK1: pattern_gen = one & mask;
      MODE_WALK0: pattern_gen = ~one & mask;
      MODE_COUNT: pattern_gen = idx & mask;
      default:    pattern_gen = (idx[0] ? 32'hAAAA_AAAA : 32'h5555_5555) & mask;
    endcase
  endfunction

endpackage

// File: rtl/pad_sync.sv
// N-stage, WIDTH-bit flop synchronizer for the asynchronous input-pad bus.
module pad_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_loopback_sequencer.sv
// Drives test patterns onto the output pads and checks them against the looped-back input pads.
// Optional checker self-test (inject/inject_idx ports) enabled by PAD_LOOPBACK_INJECT_EN.
module pad_loopback_sequencer
  import pad_loopback_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
`ifdef PAD_LOOPBACK_INJECT_EN
  input  logic             inject,
  input  logic [3:0]       inject_idx,
`endif
  output logic [WIDTH-1:0] uo_CORE2PAD,
  input  logic [WIDTH-1:0] ui_PAD2CORE,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] first_fail_pattern,
  output logic [WIDTH-1:0] first_fail_vec
);

  localparam int IDX_W        = WIDTH + 1;
  localparam int SETTLE_TOTAL = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_W        = $clog2(SETTLE_TOTAL + 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   uo_q, uo_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]         err_q, err_d;
  logic [WIDTH-1:0]   ffp_q, ffp_d, ffv_q, ffv_d;
  logic [WIDTH-1:0]   ui_sync, cmp_vec;
  logic [IDX_W-1:0]   last_idx;

  pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ui_PAD2CORE),
    .q_o (ui_sync)
  );

`ifdef PAD_LOOPBACK_INJECT_EN
  // Flip one sampled bit so the checker can be proven without a bad pad.
  always_comb begin
    cmp_vec = ui_sync;
    for (int i = 0; i < WIDTH; i++)
      if (inject && (int'(inject_idx) == i)) cmp_vec[i] = ~ui_sync[i];
  end
`else
  assign cmp_vec = ui_sync;
`endif

  assign last_idx = IDX_W'(pattern_count(mode_q, WIDTH) - 1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    uo_d    = uo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffp_d   = ffp_q;
    ffv_d   = ffv_q;
    case (state_q)
      ST_IDLE: begin
        uo_d = '0;
        if (start) begin
          mode_d  = mode_e'(mode);
          err_d   = '0;
          ffp_d   = '0;
          ffv_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        uo_d    = WIDTH'(pattern_gen(mode_q, 32'(idx_q), WIDTH));
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_TOTAL - 1)) state_d = ST_SAMPLE;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      ST_SAMPLE: begin
        if (cmp_vec != uo_q) begin
          if (err_q == '0) begin
            ffp_d = uo_q;
            ffv_d = cmp_vec;
          end
          if (err_q != ERR_MAX) err_d = err_q + 8'd1;
        end
        // done/pass are registered here so they are visible during the DONE cycle.
        if (idx_q == last_idx) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          uo_d    = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WALK1;
      idx_q   <= '0;
      cnt_q   <= '0;
      uo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffp_q   <= '0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      uo_q    <= uo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffp_q   <= ffp_d;
      ffv_q   <= ffv_d;
    end
  end

  assign uo_CORE2PAD        = uo_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign err_count          = err_q;
  assign first_fail_pattern = ffp_q;
  assign first_fail_vec     = ffv_q;

endmodule

// File: tb/tb_pad_loopback_sequencer.sv
// Scoreboard bench: external 3-cycle loopback with selectable pad faults.
module tb_pad_loopback_sequencer;

  localparam int W = 12;

  typedef struct {
    int           err;
    logic [W-1:0] ffp;
    logic [W-1:0] ffv;
    logic         pass;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   mode;
  logic [W-1:0] uo, ui;
  logic         busy, done, pass;
  logic [7:0]   err;
  logic [W-1:0] ffp, ffv;
  logic         inject;
  logic [3:0]   inject_idx;

  int   n_chk = 0, n_pass = 0, cyc = 0, fsel = 0;
  exp_t sb[$];
  logic [W-1:0] d1 = '0, d2 = '0, d3 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] fault(logic [W-1:0] v, int f);
    case (f)
      1:       return v & ~12'h020;
      2:       return {v[11:4], v[2], v[3], v[1:0]};
      3:       return v | 12'h800;
      default: return v;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_pat(int m, int i);
    logic [W-1:0] one = 1;
    case (m)
      0:       return one << i;
      1:       return ~(one << i);
      2:       return W'(i);
      default: return (i == 0) ? 12'h555 : 12'hAAA;
    endcase
  endfunction

  // Pad loopback: uo reaches ui three cycles later, then the selected fault applies.
  always @(posedge clk) begin
    d1 <= uo;
    d2 <= d1;
    d3 <= d2;
  end
  assign ui = fault(d3, fsel);

  pad_loopback_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .mode               (mode),
`ifdef PAD_LOOPBACK_INJECT_EN
    .inject             (inject),
    .inject_idx         (inject_idx),
`endif
    .uo_CORE2PAD        (uo),
    .ui_PAD2CORE        (ui),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .err_count          (err),
    .first_fail_pattern (ffp),
    .first_fail_vec     (ffv)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run(int m, int f, logic inj, logic [3:0] iidx, int pulse_at);
    exp_t         e;
    int           n, t0;
    bit           seen;
    logic [W-1:0] p, v, injm, one;
    one  = 1;
    injm = (inj && iidx < W) ? (one << iidx) : '0;
    n    = (m < 2) ? W : (m == 2) ? 4096 : 2;
    e.err = 0; e.ffp = '0; e.ffv = '0;
    for (int i = 0; i < n; i++) begin
      p = ref_pat(m, i);
      v = fault(p, f) ^ injm;
      if (v != p) begin
        if (e.err == 0) begin e.ffp = p; e.ffv = v; end
        if (e.err < 255) e.err++;
      end
    end
    e.pass = (e.err == 0);
    e.lat  = n * 8;
    sb.push_back(e);

    @(negedge clk);
    fsel = f; inject = inj; inject_idx = iidx; mode = m[1:0]; start = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    mode  = ~mode;
    chk("busy_after_start", busy, 1);
    seen = 0;
    for (int k = 0; k < 40000 && !seen; k++) begin
      @(negedge clk);
      start = (pulse_at > 0 && k == pulse_at);
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        chk("latency",   cyc - t0, e.lat);
        chk("err_count", err, e.err);
        chk("ff_pat",    ffp, e.ffp);
        chk("ff_vec",    ffv, e.ffv);
        chk("pass",      pass, e.pass);
        chk("busy_done", busy, 0);
        chk("uo_done",   uo, 0);
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("pass_held", pass, e.pass);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; mode = 2'd0; inject = 1'b0; inject_idx = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_ffp", ffp, 0);
    chk("rst_ffv", ffv, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 0, 1'b0, 4'd0, 20);   // ideal walking-one, stray start mid-run
    run(0, 1, 1'b0, 4'd0, 0);    // bit 5 stuck-at-0
    run(3, 2, 1'b0, 4'd0, 0);    // bits 2/3 swapped
    run(2, 3, 1'b0, 4'd0, 0);    // bit 11 stuck-at-1, saturating count
`ifdef PAD_LOOPBACK_INJECT_EN
    run(0, 0, 1'b1, 4'd0, 0);
    run(0, 0, 1'b1, 4'd13, 0);
`endif

    // Abort a faulty walking-zero run with reset at cycle 40.
    @(negedge clk);
    fsel = 1; mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_abort_err", (err != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_uo", uo, 0);
    chk("abort_err", err, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
